// File: rtl/vga_timing_decoder_if.sv
// vga_timing_decoder_if: sync inputs and decoded timing/status outputs of the VGA timing decoder
interface vga_timing_decoder_if;
  logic       clk_pixel;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       locked;
  logic       frame_start;
  logic       err;
  logic [7:0] err_count;
  modport master (
    output clk_pixel, hsync, vsync,
    input  x, y, active, locked, frame_start, err, err_count
  );
  modport slave (
    input  clk_pixel, hsync, vsync,
    output x, y, active, locked, frame_start, err, err_count
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers pixel coordinates from hsync/vsync and monitors line/frame timing for lock and errors
module vga_timing_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst,
  vga_timing_decoder_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_MAX   = 2 * H_TOTAL - 1;
  localparam int HW      = $clog2(2 * H_TOTAL);
  localparam int GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [1:0] SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;

  logic          hs_prev, vs_prev, vs_pend, line_exempt, frame_exempt, bad_in_frame;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [9:0]    v_cnt, v_nxt;
  logic [1:0]    state, state_nxt;
  logic [GW-1:0] good, good_nxt;
  logic          hs_edge, vs_edge, new_frame, line_bad, frame_bad, timeout, err_nxt, in_h, in_v;

  always_comb begin
    hs_edge   = (bus.hsync == SYNC_POL) && (hs_prev != SYNC_POL);
    vs_edge   = (bus.vsync == SYNC_POL) && (vs_prev != SYNC_POL);
    new_frame = hs_edge && (vs_pend || vs_edge);
    h_nxt     = hs_edge ? '0 : (h_cnt == HW'(H_MAX)) ? h_cnt : h_cnt + 1'b1;
    v_nxt     = new_frame ? '0 : !hs_edge ? v_cnt : (v_cnt == 10'd1023) ? v_cnt : v_cnt + 10'd1;
    line_bad  = hs_edge && !line_exempt && (h_cnt != HW'(H_TOTAL - 1));
    // The line closing at frame_start belongs to the frame being judged
    frame_bad = new_frame && !frame_exempt &&
                ((v_cnt != 10'(V_TOTAL - 1)) || bad_in_frame || line_bad);
    timeout   = (state != SEARCH) && !hs_edge && (h_cnt == HW'(H_MAX - 1));
    err_nxt   = timeout || (state == TRACK && line_bad) ||
                (state == LOCKED && (line_bad || frame_bad));
    in_h      = (h_nxt >= HW'(H_START)) && (h_nxt < HW'(H_START + H_ACTIVE));
    in_v      = (v_nxt >= 10'(V_START)) && (v_nxt < 10'(V_START + V_ACTIVE));
    state_nxt = state;
    good_nxt  = good;
    if (timeout) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
    end else if (state == SEARCH) begin
      state_nxt = new_frame ? TRACK : SEARCH;
      good_nxt  = '0;
    end else if (state == TRACK) begin
      if (new_frame) begin
        good_nxt  = frame_bad ? '0 : good + 1'b1;
        state_nxt = (!frame_bad && (good + 1'b1 == GW'(LOCK_FRAMES))) ? LOCKED : TRACK;
      end
    end else if (line_bad || frame_bad) begin
      state_nxt = TRACK;
      good_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev          <= ~SYNC_POL;
      vs_prev          <= ~SYNC_POL;
      vs_pend          <= 1'b0;
      line_exempt      <= 1'b1;
      frame_exempt     <= 1'b1;
      bad_in_frame     <= 1'b0;
      h_cnt            <= '0;
      v_cnt            <= '0;
      state            <= SEARCH;
      good             <= '0;
      bus.x            <= '0;
      bus.y            <= '0;
      bus.active       <= 1'b0;
      bus.locked       <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.err          <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.err         <= 1'b0;
      if (bus.clk_pixel) begin
        hs_prev         <= bus.hsync;
        vs_prev         <= bus.vsync;
        vs_pend         <= hs_edge ? 1'b0 : (vs_pend || vs_edge);
        line_exempt     <= timeout || (line_exempt && !hs_edge);
        frame_exempt    <= timeout || (frame_exempt && !new_frame);
        bad_in_frame    <= new_frame ? 1'b0 : (bad_in_frame || line_bad);
        h_cnt           <= h_nxt;
        v_cnt           <= v_nxt;
        state           <= state_nxt;
        good            <= good_nxt;
        bus.active      <= in_h && in_v;
        bus.x           <= (in_h && in_v) ? 10'(h_nxt - HW'(H_START)) : 10'd0;
        bus.y           <= (in_h && in_v) ? v_nxt - 10'(V_START) : 10'd0;
        bus.locked      <= state_nxt == LOCKED;
        bus.frame_start <= new_frame;
        bus.err         <= err_nxt;
        bus.err_count   <= bus.err_count + 8'((err_nxt && bus.err_count != 8'hFF) ? 1 : 0);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: directed check of the decoder on a scaled 16x11 timing raster
module tb_vga_timing_decoder;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0, nbad = 0, nerr = 0, nfs = 0, fs0 = 0;

  vga_timing_decoder_if bus();
  vga_timing_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs);
    @(negedge clk);
    bus.clk_pixel = 1'b1;
    bus.hsync     = hs;
    bus.vsync     = vs;
    @(negedge clk);
    bus.clk_pixel = 1'b0;
    nerr += int'(bus.err);
    nfs  += int'(bus.frame_start);
  endtask

  task automatic frame(input int nl, input int short_l, input bit cc);
    for (int l = 0; l < nl; l++)
      for (int i = 0; i < ((l == short_l) ? HT - 1 : HT); i++) begin
        step((i < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
        if (cc && l == VST && i == HST) begin
          chk("first_active", int'(bus.active), 1);
          chk("first_x", int'(bus.x), 0);
          chk("first_y", int'(bus.y), 0);
        end
        if (cc && l == VST && i == HST - 1) chk("pre_h_active", int'(bus.active), 0);
        if (cc && l == VST + VA - 1 && i == HST + HA - 1) begin
          chk("last_active", int'(bus.active), 1);
          chk("last_x", int'(bus.x), HA - 1);
          chk("last_y", int'(bus.y), VA - 1);
        end
        if (cc && l == VST + VA - 1 && i == HST + HA) begin
          chk("post_h_active", int'(bus.active), 0);
          chk("post_h_x", int'(bus.x), 0);
        end
        if (cc && l == VST + VA && i == HST) begin
          chk("post_v_active", int'(bus.active), 0);
          chk("post_v_y", int'(bus.y), 0);
        end
      end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, int'(bus.x), 0);
    chk({tag, "_y"}, int'(bus.y), 0);
    chk({tag, "_active"}, int'(bus.active), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_fs"}, int'(bus.frame_start), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_errcnt"}, int'(bus.err_count), 0);
  endtask

  initial begin
    bus.clk_pixel = 1'b0;
    bus.hsync     = 1'b1;
    bus.vsync     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("rst");
    frame(VT, -1, 1'b0);
    frame(VT, -1, 1'b0);
    chk("lock_early", int'(bus.locked), 0);
    frame(VT, -1, 1'b1);
    chk("lock_third", int'(bus.locked), 1);
    chk("fs_count", nfs, 3);
    chk("nominal_err", nerr, 0);
    frame(VT, 5, 1'b0);
    chk("short_err", nerr, 1);
    chk("short_errcnt", int'(bus.err_count), 1);
    chk("short_unlock", int'(bus.locked), 0);
    frame(VT, -1, 1'b0);
    frame(VT, -1, 1'b0);
    chk("short_relock_early", int'(bus.locked), 0);
    frame(VT, -1, 1'b0);
    chk("short_relock", int'(bus.locked), 1);
    chk("short_errcnt_hold", int'(bus.err_count), 1);
    frame(VT - 1, -1, 1'b0);
    frame(VT, -1, 1'b0);
    chk("vshort_err", nerr, 2);
    chk("vshort_errcnt", int'(bus.err_count), 2);
    chk("vshort_unlock", int'(bus.locked), 0);
    frame(VT, -1, 1'b0);
    frame(VT, -1, 1'b0);
    chk("vshort_relock", int'(bus.locked), 1);
    repeat (2 * HT) step(1'b1, 1'b1);
    chk("timeout_err", nerr, 3);
    chk("timeout_errcnt", int'(bus.err_count), 3);
    chk("timeout_unlock", int'(bus.locked), 0);
    frame(VT, -1, 1'b0);
    frame(VT, -1, 1'b0);
    chk("timeout_relock_early", int'(bus.locked), 0);
    frame(VT, -1, 1'b0);
    chk("timeout_relock", int'(bus.locked), 1);
    chk("timeout_errcnt_hold", int'(bus.err_count), 3);
    frame(2, -1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    chk("pre_rst_locked", int'(bus.locked), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    fs0 = nfs;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < HT; i++) step((i < HS) ? 1'b0 : 1'b1, 1'b1);
    chk("rst_no_fs", nfs, fs0);
    frame(VT, -1, 1'b0);
    chk("rst_first_fs", nfs, fs0 + 1);
    chk("rst_errcnt", int'(bus.err_count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the VGA sync generator. Samples hsync/vsync on each pixel-enable strobe, recovers pixel coordinates and the active-video flag, and checks line and frame lengths against the expected 640x480 timing.
- Reports lock status and timing errors.
- Used as an in-fabric monitor and bench checker for the display path, and as the coordinate source for downstream pixel consumers.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to lock
- Derived: H_TOTAL=800, V_TOTAL=525, H_START=H_SYNC+H_BP=144, V_START=V_SYNC+V_BP=35

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_pixel  in  1  pixel-enable strobe, one clk wide, synchronous to clk
- hsync  in  1  horizontal sync, synchronous to clk
- vsync  in  1  vertical sync, synchronous to clk
- x  out  10  pixel column, valid when active=1
- y  out  10  line row, valid when active=1
- active  out  1  current sample lies in the active region
- locked  out  1  timing lock achieved
- frame_start  out  1  one-clk pulse on the line-0 hsync edge
- err  out  1  one-clk pulse on any timing violation
- err_count  out  8  saturating violation count

Behaviour:
- Timing basis
  - One clock domain; reset is synchronous and active-high.
  - All state advances only on clk cycles where clk_pixel=1 ("sample").
  - Outputs are registered and update on the clk edge ending the sample cycle (latency 1 clk).
- Reset
  - x=0, y=0, active=0, locked=0, frame_start=0, err=0, err_count=0.
  - h_cnt=0, v_cnt=0, previous sync registers hold the deasserted level, state=SEARCH.
  - Reset mid-frame discards all progress; the block reacquires from SEARCH.
- Edge detection
  - An hsync leading edge (hs_edge) is a sample where hsync==SYNC_POL and the previous sampled hsync!=SYNC_POL. vsync edges are detected the same way.
  - A vsync leading edge sets vs_pend. vs_pend clears at the next hs_edge, or at the same sample if both edges coincide.
- Horizontal counting
  - On hs_edge: h_cnt:=0, and the previous line length is h_cnt+1.
  - Otherwise h_cnt increments, saturating at 2*H_TOTAL-1.
- Vertical counting
  - On hs_edge with vs_pend (or a coincident vsync edge): v_cnt:=0, frame_start pulses, and the previous frame's line count is v_cnt+1.
  - Otherwise, on hs_edge, v_cnt increments, saturating at 1023.
- Active region and coordinates
  - active = (H_START <= h_cnt < H_START+H_ACTIVE) && (V_START <= v_cnt < V_START+V_ACTIVE).
  - x = h_cnt-H_START and y = v_cnt-V_START when active; otherwise x and y hold 0.
- Checks, made at hs_edge
  - line_bad: line length != H_TOTAL. The first hs_edge after SEARCH is exempt.
  - frame_bad: at frame_start, line count != V_TOTAL, or any line_bad occurred in that frame. The first frame_start after SEARCH is exempt.
- Timeout: if h_cnt reaches 2*H_TOTAL-1 (hsync lost), pulse err, go to SEARCH, locked:=0.
- State machine
  - SEARCH: on the first frame_start → TRACK, good:=0.
  - TRACK: at each frame_start, a good frame increments good; when good reaches LOCK_FRAMES → LOCKED, locked:=1. A bad frame sets good:=0 and stays in TRACK.
  - LOCKED: on line_bad or frame_bad, pulse err, locked:=0, good:=0 → TRACK.
  - In TRACK, line_bad also pulses err.
- Error reporting
  - err_count increments on every err pulse and saturates at 255.
  - Simultaneous line_bad and frame_bad produce a single err pulse and one increment.
- Coincident hsync and vsync edges are legal: the current line becomes line 0.

Test Plan:
- Nominal 800x525 stream (clk_pixel every 4th clk, active-low syncs): frame_start every 420000 samples. locked rises at the third frame_start (first after SEARCH, plus 2 good). err never pulses.
- Coordinates while locked: sample at h_cnt=144, v_cnt=35 → active=1, x=0, y=0. At h_cnt=783, v_cnt=514 → x=639, y=479. At h_cnt=784 → active=0, x=0.
- One line shortened to 799 samples while locked: err pulses exactly once at the next hs_edge, locked=0, err_count=1. Re-lock occurs after 2 further good frames.
- Frame with 524 lines while locked: single err at frame_start, err_count increments by 1, locked=0.
- hsync held deasserted for 1600 samples: err pulses, state returns to SEARCH. Restoring syncs relocks after 3 frame_starts.
- Assert rst mid-line while locked: the next clk shows all outputs 0, and frame_start does not pulse until a vsync edge followed by an hs_edge.
